// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
    logic        p0_req;
    logic        p0_we;
    logic [2:0]  p0_width;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_gnt;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p0_err;

    logic        p1_req;
    logic        p1_we;
    logic [2:0]  p1_width;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_gnt;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;
    logic        p1_err;

    logic [2:0]  mem_width;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_width, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_width, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output mem_width, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output p0_req, p0_we, p0_width, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_req, p1_we, p1_width, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  mem_width, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the single-port byte-addressed data memory.
// Port 0 is the load/store unit, port 1 the fetch path; one access per grant.
module mem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e      state_q, state_d;
    logic        rr_q, rr_d;
    logic        port_q, port_d;
    logic        we_q, we_d;
    logic [2:0]  width_q, width_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        legal;
    logic [31:0] mask;
    logic        can_acc;
    logic        win;
    logic        gnt0, gnt1;
    logic        in_acc, in_resp;

    assign in_acc  = (state_q == ACCESS);
    assign in_resp = (state_q == RESP);
    assign legal   = (width_q == 3'd1) || (width_q == 3'd2) || (width_q == 3'd4);

    always_comb begin
        mask = 32'h0;
        case (width_q)
            3'd1:    mask = 32'h0000_00FF;
            3'd2:    mask = 32'h0000_FFFF;
            3'd4:    mask = 32'hFFFF_FFFF;
            default: mask = 32'h0;
        endcase
    end

    // win names the selected port; a lone requester wins regardless of rr.
    always_comb begin
        can_acc = !rst && !in_acc;
        if (bus.p0_req && bus.p1_req) begin
            win = FIXED_PRIO ? 1'b0 : rr_q;
        end else begin
            win = !bus.p0_req;
        end
        gnt0 = can_acc && bus.p0_req && !win;
        gnt1 = can_acc && bus.p1_req && win;
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        port_d  = port_q;
        we_d    = we_q;
        width_d = width_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ACCESS: begin
                rdata_d = (we_q || !legal) ? 32'h0 : (bus.mem_rdata & mask);
                err_d   = !legal;
                state_d = RESP;
            end
            default: begin
                if (gnt0 || gnt1) begin
                    port_d  = win;
                    rr_d    = !win;
                    we_d    = win ? bus.p1_we    : bus.p0_we;
                    width_d = win ? bus.p1_width : bus.p0_width;
                    addr_d  = win ? bus.p1_addr  : bus.p0_addr;
                    wdata_d = win ? bus.p1_wdata : bus.p0_wdata;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            width_q <= 3'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            port_q  <= port_d;
            we_q    <= we_d;
            width_q <= width_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Reset in the access cycle must kill the write combinationally.
    assign bus.mem_we    = in_acc && we_q && legal && !rst;
    assign bus.mem_width = (in_acc && legal) ? width_q : 3'd0;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.p0_gnt    = gnt0;
    assign bus.p1_gnt    = gnt1;
    assign bus.p0_rvalid = in_resp && !port_q;
    assign bus.p1_rvalid = in_resp && port_q;
    assign bus.p0_rdata  = port_q ? 32'h0 : rdata_q;
    assign bus.p1_rdata  = port_q ? rdata_q : 32'h0;
    assign bus.p0_err    = in_resp && !port_q && err_q;
    assign bus.p1_err    = in_resp && port_q && err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer for the core's byte-addressed, single-port data memory. It shares that memory between the load/store unit (port 0) and the instruction fetch path (port 1). Each accepted request becomes exactly one memory access cycle with a registered read response. It sits between the two requesters and the memory's width/we/addr/w_data/r_data interface.

## Interface
Parameters:
- FIXED_PRIO, 0: 0 = round-robin between ports; 1 = port 0 always wins contention.

Ports (clock and reset first). One clock; reset is synchronous and active-high.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- pN_req  in  1  port N (N = 0, 1) request. Must be held, with its fields stable, until pN_gnt.
- pN_we  in  1  port N write enable.
- pN_width  in  3  port N access width in bytes. Legal values are 1, 2 and 4.
- pN_addr  in  32  port N byte address.
- pN_wdata  in  32  port N write data. Byte lanes are used from bit 0 upward.
- pN_gnt  out  1  port N request accepted this cycle. Combinational.
- pN_rvalid  out  1  port N response valid. One-cycle pulse, registered.
- pN_rdata  out  32  port N read data. Zero-extended to width. Meaningful only while pN_rvalid is high.
- pN_err  out  1  port N illegal width. Valid with pN_rvalid.
- mem_width  out  3  width presented to memory.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  combinational read data from memory.

## Operation
- FSM states:
  - IDLE.
  - ACCESS: drives memory for exactly one cycle.
  - RESP: response pulse. New grants are also allowed in this state.
- Acceptance is legal in IDLE or RESP only.
  - In an accept cycle the arbiter selects a winner among asserted reqs and raises that port's gnt.
  - It latches we/width/addr/wdata and the port id, then moves to ACCESS.
  - With no req, RESP goes to IDLE and IDLE stays in IDLE.
- ACCESS:
  - mem_* outputs are driven from the latched fields.
  - mem_we equals the latched we ANDed with legal width.
  - mem_rdata is captured into the response register. Bits above width are forced to 0; for writes, 0 is captured.
  - The FSM always moves to RESP.
- RESP:
  - The latched port's rvalid is 1 and its rdata is the registered data.
  - err = 1 if the latched width was not in {1, 2, 4}.
  - The other port's rvalid is 0.
- Illegal width: the memory is not written (mem_we = 0, mem_width = 0) and rdata = 0. A response is still returned, with err = 1.
- Arbitration:
  - FIXED_PRIO = 0: a 1-bit rr pointer names the preferred port. On a grant it is updated to the port that did not win. With a single requester, that requester wins regardless of the pointer.
  - FIXED_PRIO = 1: port 0 wins whenever p0_req = 1.
- At most one gnt is high per cycle. gnt is never high in ACCESS.
- Outside ACCESS: mem_we = 0 and mem_width = 0. mem_addr and mem_wdata hold their last values.

## Timing
- Reset values:
  - state = IDLE, rr = port 0.
  - All gnt, rvalid and err = 0; all rdata = 0.
  - mem_we = 0, mem_width = 0, mem_addr = 0, mem_wdata = 0.
- Latency: a grant in cycle T gives ACCESS in T+1 and rvalid in T+2.
- Throughput: with back-to-back requests (grant in RESP), one access per 2 cycles.
- Request held while not granted: no side effect. Dropping req before gnt is permitted; nothing is latched.
- Simultaneous req on both ports: exactly one gnt. The loser stays pending and is granted in the next RESP.
- rst asserted during ACCESS:
  - The memory write of that cycle is suppressed: mem_we is forced to 0 while rst = 1.
  - No rvalid follows.
  - The state returns to IDLE the next cycle.
- rst asserted during RESP: rvalid drops to 0 the next cycle. No grant is issued while rst = 1.
- Address arithmetic: addr is passed through unmodified. Wrap-around of the memory size is the memory's responsibility.

## Test plan
- Reset, then idle 5 cycles: all outputs 0; mem_we never 1.
- p0 writes width 4, addr 0x10, data 0xDEADBEEF; then p0 reads width 4 at 0x10:
  - first: gnt at T, mem_we = 1 only at T+1;
  - read: rvalid at T'+2 with rdata 0xDEADBEEF, err = 0.
- Same memory contents (0xDEADBEEF at 0x10): p1 reads width 1 at 0x11, then width 2 at 0x12:
  - width 1: rdata 0x000000BE;
  - width 2: rdata 0x0000DEAD.
- Both ports request continuously for 8 grants:
  - FIXED_PRIO = 0: grants alternate p0, p1, p0, ..., one grant every 2 cycles;
  - FIXED_PRIO = 1: all 8 grants go to p0.
- p0 write with width 3 to addr 0x20: mem_we stays 0, p0_rvalid = 1 with err = 1 and rdata = 0, and memory at 0x20 is unchanged on readback.
- p0 write granted, then rst raised in the ACCESS cycle: no memory write, no rvalid, FSM in IDLE after reset. A subsequent p1 request is granted normally.
